debug_cmd_ctrl: RTL and testbench
=================================

# debug_cmd_ctrl

Command sequencer between the UART receiver and the MIPS pipeline in the debug unit. It decodes host command bytes, loads program words into instruction memory, and gates the pipeline clock enable for single-step or continuous execution. After each step or halt it triggers the register/PC/ALU dump engine and waits until that engine finishes. It is the only block that drives pipeline enable, pipeline soft reset and the instruction-memory write port.

## Interface
- NB, 32: instruction word width.
- DATA_BITS, 8: UART byte width.
- NB_IMEM_ADDR, 8: instruction-memory word-address width.

- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_uart_rx_ready  in  1  one-cycle strobe: i_uart_rx_data holds a valid byte.
- i_uart_rx_data  in  DATA_BITS  received byte.
- i_mips_halt  in  1  level, high while a halt instruction has retired.
- i_dump_done  in  1  one-cycle strobe from the dump engine: transmission complete.
- o_mips_enable  out  1  pipeline advance enable.
- o_mips_reset  out  1  one-cycle pipeline soft reset (PC and pipeline registers).
- o_imem_wr_en  out  1  one-cycle instruction-memory write strobe.
- o_imem_wr_addr  out  NB_IMEM_ADDR  word address.
- o_imem_wr_data  out  NB  instruction word.
- o_dump_start  out  1  one-cycle request to the dump engine.
- o_halted  out  1  sticky halted flag.

## Operation
- Commands are accepted only in IDLE. Codes: 'l' 0x6C load, 's' 0x73 step, 'c' 0x63 continue, 'r' 0x72 reset. Other bytes are ignored. Bytes arriving in STEP, RUN, DUMP_START or DUMP_WAIT are dropped.
- States: IDLE, LOAD_COUNT, LOAD_BYTES, STEP, RUN, DUMP_START, DUMP_WAIT.
- 'l' goes to LOAD_COUNT. The next byte is word count N.
  - N=0 returns to IDLE with no writes.
  - Otherwise go to LOAD_BYTES and take 4·N bytes, MSB first.
  - Each completed word fires o_imem_wr_en for one cycle, with the address counting from 0. The address counter wraps modulo 2^NB_IMEM_ADDR.
  - After the last word, o_mips_reset pulses for one cycle, o_halted clears, and the FSM returns to IDLE.
- 's': if o_halted=1, ignore. Otherwise STEP (one cycle, o_mips_enable=1), then DUMP_START (one cycle, o_dump_start=1), then DUMP_WAIT.
- 'c': if o_halted=1, ignore. Otherwise RUN, with o_mips_enable=1 every cycle. When i_mips_halt=1 is sampled in RUN, set o_halted and go to DUMP_START.
- DUMP_WAIT holds until i_dump_done, then returns to IDLE. i_dump_done in any other state is ignored.
- 'r': o_mips_reset pulses for one cycle and o_halted clears. Stay in IDLE.
- Outputs o_mips_enable, o_dump_start, o_mips_reset and o_imem_wr_en are registered and mutually exclusive.

## Timing
- Reset: all outputs 0, FSM in IDLE, halted 0, address and byte counters 0. Reset mid-load discards the partial word; words already written remain in memory.
- Command latency: a strobe at edge k changes state at edge k. The corresponding output is high during cycle k+1.
- Step: o_mips_enable high for exactly 1 cycle. o_dump_start follows in the next cycle.
- Run: the cycle in which i_mips_halt is sampled still has o_mips_enable=1. Enable drops one cycle later, when o_dump_start rises.
- Load: the write strobe appears in the cycle after the 4th byte strobe of each word. Address and data are stable during the strobe.
- rx strobes on consecutive cycles must be supported.

## Structure
- Shared debug package: command byte constants, state encoding, and DATA_BITS/NB defaults.
- One sub-module, uart_word_assembler: shifts in DATA_BITS bytes MSB first and emits a NB-bit word plus a one-cycle valid; it has a synchronous clear. The FSM and counters stay in debug_cmd_ctrl.

## Test plan
- Reset, then 0x44 with rx_ready=0 -> all outputs stay 0 and the FSM stays in IDLE.
- 'l', 0x02, bytes 1B A5 E9 3F DE AD BE EF -> writes 0x1BA5E93F@0 and 0xDEADBEEF@1, then one o_mips_reset pulse, then IDLE.
- 's' -> o_mips_enable for exactly 1 cycle, then o_dump_start for 1 cycle. A 'c' sent during DUMP_WAIT is ignored; a later i_dump_done returns the FSM to IDLE.
- 'c', with i_mips_halt raised after 20 cycles -> enable high for 21 cycles, o_halted=1, dump started. A following 's' produces no enable.
- 'r' while halted -> one o_mips_reset pulse, o_halted=0, and 's' then works.
- Async reset in the middle of an 'l' with N=3, after 6 bytes -> only word 0 written, FSM in IDLE, and the next load starts at address 0.

Source files
------------

// File: rtl/debug_cmd_ctrl_pkg.sv
// Shared debug-unit definitions: host command bytes, sequencer states and width defaults.
package debug_cmd_ctrl_pkg;

    localparam int NB_DEF           = 32;
    localparam int DATA_BITS_DEF    = 8;
    localparam int NB_IMEM_ADDR_DEF = 8;

    localparam logic [7:0] CMD_LOAD  = 8'h6C;  // 'l'
    localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
    localparam logic [7:0] CMD_CONT  = 8'h63;  // 'c'
    localparam logic [7:0] CMD_RESET = 8'h72;  // 'r'

    typedef enum logic [2:0] {
        IDLE,
        LOAD_COUNT,
        LOAD_BYTES,
        STEP,
        RUN,
        DUMP_START,
        DUMP_WAIT
    } state_t;

endpackage

// File: rtl/uart_word_assembler.sv
// Packs UART bytes (MSB first) into instruction words; one-cycle valid per completed word.
module uart_word_assembler #(
    parameter int NB        = 32,
    parameter int DATA_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_byte_valid,
    input  logic [DATA_BITS-1:0] i_byte,
    output logic [NB-1:0]        o_word,
    output logic                 o_word_valid
);
    localparam int BPW = NB / DATA_BITS;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0] byte_cnt;
    logic [NB-1:0] shift;
    logic [NB-1:0] shift_next;

    assign shift_next = {shift[NB-DATA_BITS-1:0], i_byte};

    // o_word only updates on completion so it stays stable while the next word streams in
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            byte_cnt     <= '0;
            shift        <= '0;
            o_word       <= '0;
            o_word_valid <= 1'b0;
        end else begin
            o_word_valid <= 1'b0;
            if (i_clear) begin
                byte_cnt <= '0;
                shift    <= '0;
            end else if (i_byte_valid) begin
                shift <= shift_next;
                if (byte_cnt == CW'(BPW - 1)) begin
                    byte_cnt     <= '0;
                    o_word       <= shift_next;
                    o_word_valid <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/debug_cmd_ctrl.sv
// Debug command sequencer: decodes host bytes, loads instruction memory, steps/runs the
// pipeline and hands off to the dump engine after each step or halt.
module debug_cmd_ctrl
    import debug_cmd_ctrl_pkg::*;
#(
    parameter int NB           = NB_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF,
    parameter int NB_IMEM_ADDR = NB_IMEM_ADDR_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_uart_rx_ready,
    input  logic [DATA_BITS-1:0]    i_uart_rx_data,
    input  logic                    i_mips_halt,
    input  logic                    i_dump_done,
    output logic                    o_mips_enable,
    output logic                    o_mips_reset,
    output logic                    o_imem_wr_en,
    output logic [NB_IMEM_ADDR-1:0] o_imem_wr_addr,
    output logic [NB-1:0]           o_imem_wr_data,
    output logic                    o_dump_start,
    output logic                    o_halted
);
    state_t                  state;
    logic [DATA_BITS-1:0]    words_left;
    logic [NB_IMEM_ADDR-1:0] wr_addr;
    logic                    asm_clear;
    logic                    asm_byte_valid;
    logic                    asm_valid;
    logic [NB-1:0]           asm_word;

    // Assembler is held clear outside LOAD_BYTES so a stray byte after the last word is discarded
    assign asm_clear      = (state != LOAD_BYTES);
    assign asm_byte_valid = i_uart_rx_ready && (state == LOAD_BYTES);

    uart_word_assembler #(
        .NB        (NB),
        .DATA_BITS (DATA_BITS)
    ) u_word_asm (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (asm_clear),
        .i_byte_valid (asm_byte_valid),
        .i_byte       (i_uart_rx_data),
        .o_word       (asm_word),
        .o_word_valid (asm_valid)
    );

    assign o_imem_wr_en   = asm_valid;
    assign o_imem_wr_data = asm_word;
    assign o_imem_wr_addr = wr_addr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            words_left    <= '0;
            wr_addr       <= '0;
            o_mips_enable <= 1'b0;
            o_dump_start  <= 1'b0;
            o_mips_reset  <= 1'b0;
            o_halted      <= 1'b0;
        end else begin
            o_mips_enable <= 1'b0;
            o_dump_start  <= 1'b0;
            o_mips_reset  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_uart_rx_ready) begin
                        if (i_uart_rx_data == DATA_BITS'(CMD_LOAD)) begin
                            state   <= LOAD_COUNT;
                            wr_addr <= '0;
                        end else if (i_uart_rx_data == DATA_BITS'(CMD_STEP) && !o_halted) begin
                            state         <= STEP;
                            o_mips_enable <= 1'b1;
                        end else if (i_uart_rx_data == DATA_BITS'(CMD_CONT) && !o_halted) begin
                            state         <= RUN;
                            o_mips_enable <= 1'b1;
                        end else if (i_uart_rx_data == DATA_BITS'(CMD_RESET)) begin
                            o_mips_reset <= 1'b1;
                            o_halted     <= 1'b0;
                        end
                    end
                end
                LOAD_COUNT: begin
                    if (i_uart_rx_ready) begin
                        if (i_uart_rx_data == '0) begin
                            state <= IDLE;
                        end else begin
                            words_left <= i_uart_rx_data;
                            state      <= LOAD_BYTES;
                        end
                    end
                end
                LOAD_BYTES: begin
                    // Soft reset follows the final write strobe by one cycle to keep them exclusive
                    if (asm_valid) begin
                        wr_addr    <= wr_addr + 1'b1;
                        words_left <= words_left - 1'b1;
                        if (words_left == DATA_BITS'(1)) begin
                            o_mips_reset <= 1'b1;
                            o_halted     <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                STEP: begin
                    o_dump_start <= 1'b1;
                    state        <= DUMP_START;
                end
                RUN: begin
                    if (i_mips_halt) begin
                        o_halted     <= 1'b1;
                        o_dump_start <= 1'b1;
                        state        <= DUMP_START;
                    end else begin
                        o_mips_enable <= 1'b1;
                    end
                end
                DUMP_START: state <= DUMP_WAIT;
                DUMP_WAIT: begin
                    if (i_dump_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_cmd_ctrl.sv
// Scoreboard bench for debug_cmd_ctrl: stimulus queues expected output events, a monitor
// turns observed output activity into events and checks them in order.
module tb_debug_cmd_ctrl;
    localparam int NB           = 32;
    localparam int DATA_BITS    = 8;
    localparam int NB_IMEM_ADDR = 8;

    typedef enum int {EV_EN, EV_WR, EV_RST, EV_DUMP, EV_HALT} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    logic                    i_clk = 1'b0;
    logic                    i_reset = 1'b1;
    logic                    i_uart_rx_ready = 1'b0;
    logic [DATA_BITS-1:0]    i_uart_rx_data = '0;
    logic                    i_mips_halt = 1'b0;
    logic                    i_dump_done = 1'b0;
    logic                    o_mips_enable;
    logic                    o_mips_reset;
    logic                    o_imem_wr_en;
    logic [NB_IMEM_ADDR-1:0] o_imem_wr_addr;
    logic [NB-1:0]           o_imem_wr_data;
    logic                    o_dump_start;
    logic                    o_halted;

    always #5 i_clk = ~i_clk;

    debug_cmd_ctrl #(
        .NB           (NB),
        .DATA_BITS    (DATA_BITS),
        .NB_IMEM_ADDR (NB_IMEM_ADDR)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_uart_rx_ready (i_uart_rx_ready),
        .i_uart_rx_data  (i_uart_rx_data),
        .i_mips_halt     (i_mips_halt),
        .i_dump_done     (i_dump_done),
        .o_mips_enable   (o_mips_enable),
        .o_mips_reset    (o_mips_reset),
        .o_imem_wr_en    (o_imem_wr_en),
        .o_imem_wr_addr  (o_imem_wr_addr),
        .o_imem_wr_data  (o_imem_wr_data),
        .o_dump_start    (o_dump_start),
        .o_halted        (o_halted)
    );

    function automatic void expect_ev(input ev_kind_t k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endfunction

    function automatic void post(input ev_kind_t k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got %s a=%h d=%h, required no event", k.name(), a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a != a || e.d != d) begin
                fails++;
                $display("FAIL event_order: got %s a=%h d=%h, required %s a=%h d=%h",
                         k.name(), a, d, e.kind.name(), e.a, e.d);
            end
        end
    endfunction

    // Monitor: enable runs are reported as one event carrying their length
    int   en_len = 0;
    logic halted_q = 1'b0;
    always @(negedge i_clk) begin
        if (i_reset) begin
            en_len   = 0;
            halted_q = 1'b0;
        end else begin
            int n_act;
            n_act = int'(o_mips_enable) + int'(o_dump_start) + int'(o_mips_reset) + int'(o_imem_wr_en);
            if (n_act > 0) begin
                tests++;
                if (n_act > 1) begin
                    fails++;
                    $display("FAIL exclusive_outputs: got %0d active strobes, required at most 1", n_act);
                end
            end
            if (o_mips_enable) en_len++;
            else if (en_len != 0) begin
                post(EV_EN, en_len, 32'h0);
                en_len = 0;
            end
            if (o_imem_wr_en) post(EV_WR, 32'(o_imem_wr_addr), o_imem_wr_data);
            if (o_mips_reset) post(EV_RST, 32'h0, 32'h0);
            if (o_dump_start) post(EV_DUMP, 32'h0, 32'h0);
            if (o_halted != halted_q) begin
                post(EV_HALT, 32'(o_halted), 32'h0);
                halted_q = o_halted;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        i_uart_rx_data  = b;
        i_uart_rx_ready = 1'b1;
        @(negedge i_clk);
        i_uart_rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic dump_done_pulse();
        i_dump_done = 1'b1;
        @(negedge i_clk);
        i_dump_done = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        tests++;
        if ({o_mips_enable, o_mips_reset, o_imem_wr_en, o_dump_start, o_halted} !== 5'b0 ||
            o_imem_wr_addr !== '0) begin
            fails++;
            $display("FAIL %s: got en=%b rst=%b wr=%b dump=%b halted=%b addr=%h, required all 0",
                     name, o_mips_enable, o_mips_reset, o_imem_wr_en, o_dump_start, o_halted, o_imem_wr_addr);
        end
    endtask

    initial begin
        logic [7:0] load_a[8] = '{8'h1B, 8'hA5, 8'hE9, 8'h3F, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        logic [7:0] load_b[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [7:0] load_c[4] = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};

        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        check_quiet("reset_state");

        // Non-command data with and without strobe: nothing happens
        i_uart_rx_data = 8'h44;
        idle(4);
        send(8'h44);
        idle(2);
        check_quiet("idle_after_junk");

        // Two-word load
        expect_ev(EV_WR, 32'd0, 32'h1BA5E93F);
        expect_ev(EV_WR, 32'd1, 32'hDEADBEEF);
        expect_ev(EV_RST, 32'h0, 32'h0);
        send(8'h6C);
        send(8'h02);
        foreach (load_a[i]) send(load_a[i]);
        idle(4);

        // Single step; a 'c' during DUMP_WAIT is dropped
        expect_ev(EV_EN, 32'd1, 32'h0);
        expect_ev(EV_DUMP, 32'h0, 32'h0);
        send(8'h73);
        idle(3);
        send(8'h63);
        idle(3);
        dump_done_pulse();
        idle(2);

        // Continuous run until halt sampled 21 edges after the command
        expect_ev(EV_EN, 32'd21, 32'h0);
        expect_ev(EV_DUMP, 32'h0, 32'h0);
        expect_ev(EV_HALT, 32'd1, 32'h0);
        send(8'h63);
        repeat (20) @(negedge i_clk);
        i_mips_halt = 1'b1;
        idle(4);
        dump_done_pulse();
        idle(2);
        tests++;
        if (o_halted !== 1'b1) begin
            fails++;
            $display("FAIL halted_flag: got %b, required 1", o_halted);
        end

        // Step and continue are ignored while halted
        send(8'h73);
        idle(4);
        send(8'h63);
        idle(4);

        // 'r' clears halted, after which a step works again
        expect_ev(EV_RST, 32'h0, 32'h0);
        expect_ev(EV_HALT, 32'd0, 32'h0);
        send(8'h72);
        i_mips_halt = 1'b0;
        idle(3);
        expect_ev(EV_EN, 32'd1, 32'h0);
        expect_ev(EV_DUMP, 32'h0, 32'h0);
        send(8'h73);
        idle(3);
        dump_done_pulse();
        idle(2);

        // Zero-word load produces no activity
        send(8'h6C);
        send(8'h00);
        idle(3);

        // Async reset mid-load after 6 of 12 bytes
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        expect_ev(EV_WR, 32'd0, 32'h11223344);
        send(8'h6C);
        send(8'h03);
        foreach (load_b[i]) send(load_b[i]);
        idle(1);
        i_reset = 1'b1;
        idle(2);
        i_reset = 1'b0;
        idle(2);
        check_quiet("after_midload_reset");

        expect_ev(EV_WR, 32'd0, 32'hCAFEBABE);
        expect_ev(EV_RST, 32'h0, 32'h0);
        send(8'h6C);
        send(8'h01);
        foreach (load_c[i]) send(load_c[i]);
        idle(4);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_events: got %0d unobserved, required 0, next %s a=%h d=%h",
                     exp_q.size(), exp_q[0].kind.name(), exp_q[0].a, exp_q[0].d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
